rob_retire_unit: RTL and testbench
==================================

Name: rob_retire_unit

Overview:
- Back end of the rename protocol: retires ROB head entries in order and returns physical registers to the free list.
- Normal retire: pushes p_old and records rd_arch -> p_new in a committed RAT.
- Exception at head: asserts flush, drains the ROB and frees every squashed p_new, replays the committed RAT into the speculative RAT, then redirects fetch to the excepting PC.

Parameters:
- Taken from cpu_design_params; no local parameters.
- Uses NUM_A_REGS (32), PRN_WIDTH, ARN_WIDTH, ROB_IDX_WDTH, PC_SIZE (64), rob_data_t.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rob_head_valid  in  1  ROB non-empty, head entry presented
rob_head_entry  in  $bits(rob_data_t)  head entry
rob_pop  out  1  dequeue ROB head this cycle
fl_push_valid  out  1  free-list push request
fl_push_prn  out  PRN_WIDTH  register being freed
fl_push_ready  in  1  free list accepts push
retire_valid  out  1  one instruction committed this cycle
retire_rd_arch  out  ARN_WIDTH  committed destination
retire_p_new  out  PRN_WIDTH  committed mapping
flush  out  1  pipeline flush in progress
rat_restore_valid  out  1  speculative RAT write
rat_restore_arn  out  ARN_WIDTH  RAT index
rat_restore_prn  out  PRN_WIDTH  restored mapping
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  PC_SIZE  redirect target

Behaviour:
- Reset (rst_n=0 at posedge, any state):
  - state=RUN; restore counter=0; latched PC=0.
  - committed RAT crat[i]=i for all i.
  - All outputs 0 from the following cycle.
- "Frees" means: rob_head_entry.valid && writes_rd && rd_arch!=0. rd_arch==0 never allocates, so it never frees.
- Push handshake: a push completes when fl_push_valid && fl_push_ready.
  - Max one push per cycle.
  - rob_pop asserts only in a cycle where any required push completes.
  - fl_push_prn is held stable while waiting, because the head does not change until popped.
- rob_pop, fl_push_*, retire_* are combinational from state and head.
- flush, rat_restore_*, redirect_* are driven from registered state.
- State RUN (flush=0):
  - Head not valid, or entry.valid=0, or done=0: no pop, no push.
  - done=1, exception=0:
    - If frees: fl_push_valid=1 with p_old. On handshake: rob_pop=1, retire_valid=1, crat[rd_arch]<=p_new.
    - If it does not free: rob_pop=1 with no push. retire_valid=1 when entry.valid.
  - done=1, exception=1:
    - If frees: push p_new, since the result is discarded.
    - On pop: latch pc, go to DRAIN. No retire_valid; crat unchanged.
    - Blocked by fl_push_ready=0 means state is held.
- State DRAIN (flush=1):
  - Each head is popped regardless of done or exception.
  - p_new is pushed when the entry frees, with the same handshake rule.
  - entry.valid=0 entries pop with no push.
  - When rob_head_valid=0, go to RESTORE with counter=0.
- State RESTORE (flush=1):
  - Each cycle: rat_restore_valid=1, arn=counter, prn=crat[counter]; counter++.
  - After index NUM_A_REGS-1 (32 cycles total), go to REDIRECT.
- State REDIRECT (flush=1):
  - redirect_valid=1 and redirect_pc=latched pc for exactly one cycle, then RUN.
  - flush=0 the next cycle.
- Counter width is ARN_WIDTH+1 so it does not wrap before reaching NUM_A_REGS.
- The frontend stalls while flush=1. The block ignores rename activity and never pushes more than one register per cycle.

Test Plan:
- Head {valid,done,writes_rd, rd=5, p_old=5, p_new=40}, ready=1 -> same cycle: push prn 5, rob_pop=1, retire rd=5 p_new=40. A later flush restore shows arn 5 -> 40.
- Same entry with fl_push_ready=0 for 3 cycles -> rob_pop=0 and fl_push_prn=5 stable for 3 cycles; pop and retire on cycle 4.
- Head writes_rd=1, rd=0; then head done=0 -> first pops with no push; second produces no pop for any number of cycles.
- Exception head pc=0x1000 p_new=33, followed by entries p_new 34 and 35 -> pushes 33, 34, 35 in order. flush rises, then 32 restore writes (arn 0..31, identity except committed updates), then one-cycle redirect to 0x1000. flush falls the next cycle.
- Exception entry with writes_rd=0, ROB otherwise empty -> no push, DRAIN lasts 1 cycle, 32 restores, redirect.
- Assert rst_n=0 at RESTORE counter=10 -> next cycle state RUN, all outputs 0. A subsequent flush restores identity mappings.

Source files
------------

// File: rtl/rob_retire_unit.sv
// ROB retire unit: in-order commit, free-list returns and
// exception recovery (drain, committed-RAT replay, redirect).
package cpu_design_params;
    localparam int NUM_A_REGS   = 32;
    localparam int PRN_WIDTH    = 6;
    localparam int ARN_WIDTH    = 5;
    localparam int ROB_IDX_WDTH = 4;
    localparam int PC_SIZE      = 64;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 exception;
        logic                 writes_rd;
        logic [ARN_WIDTH-1:0] rd_arch;
        logic [PRN_WIDTH-1:0] p_old;
        logic [PRN_WIDTH-1:0] p_new;
        logic [PC_SIZE-1:0]   pc;
    } rob_data_t;
endpackage

module rob_retire_unit
    import cpu_design_params::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rob_head_valid,
    input  rob_data_t            rob_head_entry,
    output logic                 rob_pop,
    output logic                 fl_push_valid,
    output logic [PRN_WIDTH-1:0] fl_push_prn,
    input  logic                 fl_push_ready,
    output logic                 retire_valid,
    output logic [ARN_WIDTH-1:0] retire_rd_arch,
    output logic [PRN_WIDTH-1:0] retire_p_new,
    output logic                 flush,
    output logic                 rat_restore_valid,
    output logic [ARN_WIDTH-1:0] rat_restore_arn,
    output logic [PRN_WIDTH-1:0] rat_restore_prn,
    output logic                 redirect_valid,
    output logic [PC_SIZE-1:0]   redirect_pc
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        RESTORE,
        REDIRECT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ARN_WIDTH:0]   cnt;
    logic [ARN_WIDTH:0]   cnt_nxt;
    logic [PC_SIZE-1:0]   pc_q;
    logic [PC_SIZE-1:0]   pc_nxt;
    logic [PRN_WIDTH-1:0] crat [NUM_A_REGS];

    logic head_live;
    logic frees;
    logic commit;

    assign head_live = rob_head_valid && rob_head_entry.valid;
    assign frees     = head_live && rob_head_entry.writes_rd
                       && (rob_head_entry.rd_arch != '0);

    // Next-state and head-side handshake decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_nxt        = pc_q;
        rob_pop       = 1'b0;
        fl_push_valid = 1'b0;
        fl_push_prn   = '0;
        retire_valid  = 1'b0;
        commit        = 1'b0;
        unique case (state)
            RUN: begin
                if (head_live && rob_head_entry.done) begin
                    if (frees) begin
                        fl_push_valid = 1'b1;
                        fl_push_prn   = rob_head_entry.exception
                                        ? rob_head_entry.p_new
                                        : rob_head_entry.p_old;
                        rob_pop       = fl_push_ready;
                    end else begin
                        rob_pop = 1'b1;
                    end
                    if (rob_pop && !rob_head_entry.exception) begin
                        retire_valid = 1'b1;
                        commit       = frees;
                    end
                    if (rob_pop && rob_head_entry.exception) begin
                        state_nxt = DRAIN;
                        pc_nxt    = rob_head_entry.pc;
                    end
                end
            end
            DRAIN: begin
                if (rob_head_valid) begin
                    if (frees) begin
                        fl_push_valid = 1'b1;
                        fl_push_prn   = rob_head_entry.p_new;
                        rob_pop       = fl_push_ready;
                    end else begin
                        rob_pop = 1'b1;
                    end
                end else begin
                    state_nxt = RESTORE;
                    cnt_nxt   = '0;
                end
            end
            RESTORE: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == (ARN_WIDTH+1)'(NUM_A_REGS - 1)) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Control state, restore counter and latched exception PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pc_q  <= pc_nxt;
        end
    end

    // Committed RAT: identity after reset, updated on freeing retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_A_REGS; i++) begin
                crat[i] <= PRN_WIDTH'(i);
            end
        end else if (commit) begin
            crat[rob_head_entry.rd_arch] <= rob_head_entry.p_new;
        end
    end

    assign retire_rd_arch = retire_valid ? rob_head_entry.rd_arch : '0;
    assign retire_p_new   = retire_valid ? rob_head_entry.p_new : '0;

    assign flush             = (state != RUN);
    assign rat_restore_valid = (state == RESTORE);
    assign rat_restore_arn   = rat_restore_valid ? cnt[ARN_WIDTH-1:0] : '0;
    assign rat_restore_prn   = rat_restore_valid
                               ? crat[cnt[ARN_WIDTH-1:0]] : '0;
    assign redirect_valid    = (state == REDIRECT);
    assign redirect_pc       = redirect_valid ? pc_q : '0;

endmodule

// File: tb/tb_rob_retire_unit.sv
// Randomized bench for rob_retire_unit with a transaction-level
// model of commits, frees and committed-RAT recovery.
module tb_rob_retire_unit;
    import cpu_design_params::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rob_head_valid;
    rob_data_t            rob_head_entry;
    logic                 rob_pop;
    logic                 fl_push_valid;
    logic [PRN_WIDTH-1:0] fl_push_prn;
    logic                 fl_push_ready;
    logic                 retire_valid;
    logic [ARN_WIDTH-1:0] retire_rd_arch;
    logic [PRN_WIDTH-1:0] retire_p_new;
    logic                 flush;
    logic                 rat_restore_valid;
    logic [ARN_WIDTH-1:0] rat_restore_arn;
    logic [PRN_WIDTH-1:0] rat_restore_prn;
    logic                 redirect_valid;
    logic [PC_SIZE-1:0]   redirect_pc;

    rob_retire_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rob_head_valid    (rob_head_valid),
        .rob_head_entry    (rob_head_entry),
        .rob_pop           (rob_pop),
        .fl_push_valid     (fl_push_valid),
        .fl_push_prn       (fl_push_prn),
        .fl_push_ready     (fl_push_ready),
        .retire_valid      (retire_valid),
        .retire_rd_arch    (retire_rd_arch),
        .retire_p_new      (retire_p_new),
        .flush             (flush),
        .rat_restore_valid (rat_restore_valid),
        .rat_restore_arn   (rat_restore_arn),
        .rat_restore_prn   (rat_restore_prn),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          mcrat   [NUM_A_REGS];
    int          exp_map [NUM_A_REGS];
    int          exp_push[$];
    int          exp_ret [$];
    logic [63:0] exp_pc;
    rob_data_t   q[$];
    int          phase;
    bit          rand_ready;

    function automatic bit frees_f(input rob_data_t e);
        return e.valid && e.writes_rd && (e.rd_arch != 0);
    endfunction

    function automatic rob_data_t mk(input bit v, input bit d,
                                     input bit x, input bit w,
                                     input int rd, input int po,
                                     input int pn,
                                     input logic [63:0] pc);
        rob_data_t e;
        e.valid     = v;
        e.done      = d;
        e.exception = x;
        e.writes_rd = w;
        e.rd_arch   = ARN_WIDTH'(rd);
        e.p_old     = PRN_WIDTH'(po);
        e.p_new     = PRN_WIDTH'(pn);
        e.pc        = pc;
        return e;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_A_REGS; i++) mcrat[i] = i;
        exp_push.delete();
        exp_ret.delete();
    endtask

    // Expected pushes, commits and recovery map for the queued ROB.
    task automatic plan();
        bit exc = 0;
        foreach (q[i]) begin
            if (!exc) begin
                if (q[i].exception) begin
                    exc    = 1;
                    exp_pc = q[i].pc;
                    if (frees_f(q[i])) exp_push.push_back(q[i].p_new);
                end else begin
                    exp_ret.push_back(q[i].rd_arch * 256 + q[i].p_new);
                    if (frees_f(q[i])) begin
                        exp_push.push_back(q[i].p_old);
                        mcrat[q[i].rd_arch] = q[i].p_new;
                    end
                end
            end else if (frees_f(q[i])) begin
                exp_push.push_back(q[i].p_new);
            end
        end
        for (int i = 0; i < NUM_A_REGS; i++) exp_map[i] = mcrat[i];
    endtask

    task automatic run_seq(input int stall, input int rst_at,
                           output int first_pop);
        int       cyc  = 0;
        int       ridx = 0;
        bit       held = 0;
        bit       redir;
        bit       f;
        int       got;
        logic [PRN_WIDTH-1:0] held_prn = '0;
        first_pop = -1;
        phase     = 0;
        plan();
        forever begin
            @(posedge clk);
            #1;
            rob_head_valid = (q.size() > 0);
            rob_head_entry = (q.size() > 0) ? q[0] : '0;
            if (stall > 0) begin
                fl_push_ready = 1'b0;
                stall--;
            end else begin
                fl_push_ready = rand_ready ? ($urandom % 3 != 0) : 1'b1;
            end
            cyc++;
            @(negedge clk);
            redir = 0;
            f = (q.size() > 0) && frees_f(q[0]);
            chk("flush", flush, phase != 0);
            if (fl_push_valid && fl_push_ready) begin
                held = 0;
                if (exp_push.size() == 0) chk("push_extra", fl_push_prn, '1);
                else chk("push_prn", fl_push_prn, exp_push.pop_front());
            end else if (fl_push_valid) begin
                chk("stall_pop", rob_pop, 0);
                if (held) chk("hold_prn", fl_push_prn, held_prn);
                held     = 1;
                held_prn = fl_push_prn;
            end else begin
                held = 0;
            end
            if (retire_valid) begin
                got = int'(retire_rd_arch) * 256 + int'(retire_p_new);
                if (exp_ret.size() == 0) chk("retire_extra", got, 0);
                else chk("retire", got, exp_ret.pop_front());
            end
            if (rob_pop) begin
                if (q.size() == 0) begin
                    chk("pop_empty", 1, 0);
                end else begin
                    if (f) chk("pop_needs_push",
                               fl_push_valid && fl_push_ready, 1);
                    if (first_pop < 0) first_pop = cyc;
                    if (phase == 0 && q[0].exception) phase = 1;
                    void'(q.pop_front());
                end
            end
            if (rat_restore_valid) begin
                chk("restore_arn", rat_restore_arn, ridx);
                chk("restore_prn", rat_restore_prn, exp_map[ridx % 32]);
                ridx++;
                if (rst_at >= 0 && int'(rat_restore_arn) == rst_at) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    #1;
                    rst_n          = 1'b1;
                    rob_head_valid = 1'b0;
                    rob_head_entry = '0;
                    @(negedge clk);
                    chk("rst_flush", flush, 0);
                    chk("rst_restore", rat_restore_valid, 0);
                    chk("rst_arn", rat_restore_arn, 0);
                    chk("rst_redirect", redirect_valid, 0);
                    chk("rst_pop", rob_pop, 0);
                    chk("rst_push", fl_push_valid, 0);
                    reset_model();
                    q.delete();
                    phase = 0;
                    return;
                end
            end
            if (redirect_valid) begin
                chk("redirect_pc", redirect_pc, exp_pc);
                chk("restore_cnt", ridx, 32);
                phase = 0;
                redir = 1;
            end
            if (q.size() == 0 && phase == 0 && !redir) break;
            if (cyc > 600) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        chk("push_left", exp_push.size(), 0);
        chk("retire_left", exp_ret.size(), 0);
        exp_push.delete();
        exp_ret.delete();
        q.delete();
    endtask

    int fp;
    int n;
    int xi;

    initial begin
        rst_n          = 1'b0;
        rob_head_valid = 1'b0;
        rob_head_entry = '0;
        fl_push_ready  = 1'b0;
        rand_ready     = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_flush", flush, 0);
        chk("reset_pop", rob_pop, 0);
        chk("reset_push", fl_push_valid, 0);
        chk("reset_retire", retire_valid, 0);
        chk("reset_restore", rat_restore_valid, 0);
        chk("reset_redirect", redirect_valid, 0);

        q.push_back(mk(1, 1, 0, 1, 5, 5, 40, 64'h100));
        run_seq(0, -1, fp);
        chk("t1_pop_cycle", fp, 1);

        q.push_back(mk(1, 1, 0, 1, 6, 6, 41, 64'h104));
        run_seq(3, -1, fp);
        chk("t2_pop_cycle", fp, 4);

        q.push_back(mk(1, 1, 0, 1, 0, 9, 50, 64'h108));
        run_seq(0, -1, fp);
        chk("t3_pop_cycle", fp, 1);

        @(posedge clk);
        #1;
        rob_head_valid = 1'b1;
        rob_head_entry = mk(1, 0, 0, 1, 7, 7, 51, 64'h10c);
        fl_push_ready  = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("notdone_pop", rob_pop, 0);
            chk("notdone_push", fl_push_valid, 0);
            @(posedge clk);
        end
        #1 rob_head_valid = 1'b0;

        q.push_back(mk(1, 1, 1, 1, 7, 7, 33, 64'h1000));
        q.push_back(mk(1, 0, 0, 1, 8, 8, 34, 64'h1004));
        q.push_back(mk(1, 1, 1, 1, 9, 9, 35, 64'h1008));
        run_seq(0, -1, fp);

        q.push_back(mk(1, 1, 1, 0, 4, 4, 36, 64'h2000));
        run_seq(0, -1, fp);

        q.push_back(mk(1, 1, 1, 1, 3, 3, 37, 64'h3000));
        run_seq(0, 10, fp);

        q.push_back(mk(1, 1, 1, 0, 1, 1, 38, 64'h4000));
        run_seq(0, -1, fp);

        rand_ready = 1;
        repeat (40) begin
            n  = $urandom_range(1, 6);
            xi = ($urandom % 2) ? $urandom_range(0, n - 1) : -1;
            for (int i = 0; i < n; i++) begin
                if (xi < 0 || i <= xi) begin
                    q.push_back(mk(1, 1, i == xi, $urandom % 4 != 0,
                                   ($urandom % 5 == 0) ? 0
                                   : $urandom_range(1, 31),
                                   $urandom_range(0, 63),
                                   $urandom_range(0, 63),
                                   {$urandom, $urandom}));
                end else begin
                    q.push_back(mk($urandom % 4 != 0, $urandom % 2,
                                   $urandom % 2, $urandom % 4 != 0,
                                   $urandom_range(0, 31),
                                   $urandom_range(0, 63),
                                   $urandom_range(0, 63),
                                   {$urandom, $urandom}));
                end
            end
            run_seq($urandom_range(0, 2), -1, fp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
